histogram_sequencer: RTL and testbench
======================================

# histogram_sequencer

Frame-level controller for the median-filter/histogram datapath. On a host request it clears the histogram, pulses filter start, waits for filter completion, then streams out the X and Y projection histograms while tracking each axis's peak bin. A watchdog aborts any phase that stalls. It sits between the host/control logic and the histogram top-level, and drives that block's start, clear and read controls.

## Interface
Parameters:
- NBINS, 256: bins per axis; index width is 8.
- TIMEOUT, 1048575: max cycles spent in any wait state before abort; 20-bit counter.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- frameReq  in  1  level; a new frame is accepted when high in IDLE.
- frameBusy  out  1  high in every state except IDLE.
- frameDone  out  1  one-cycle pulse on successful completion.
- frameError  out  1  sticky; set on watchdog abort, cleared on next accepted frameReq.
- start  out  1  one-cycle pulse to the filter and histogram.
- filterReady  in  1  filter idle and able to start.
- filterDone  in  1  filter finished the frame (level or pulse).
- clearHistogram  out  1  held high in CLEAR.
- histogramClear  in  1  histogram clear acknowledge.
- readHistogram  out  1  held high in READ.
- xValid / yValid  in  1 each  bin-valid strobes from the histogram.
- xHistogramOut / yHistogramOut  in  8 each  bin counts.
- binIndex  out  8  index of the bin currently forwarded.
- xBin / yBin  out  8 each  registered bin counts.
- binValid  out  1  high when both xBin and yBin are valid for binIndex.
- xPeakIndex / yPeakIndex  out  8 each  index of the max bin of the last completed frame.
- xPeakValue / yPeakValue  out  8 each  value of that max bin.

## Operation
- States: IDLE, CLEAR, WAIT_READY, START, FILTER, READ, DONE, ERROR.
- IDLE:
  - frameReq=1 clears frameError, clears the peak accumulators and goes to CLEAR.
- CLEAR:
  - clearHistogram=1.
  - histogramClear=1 goes to WAIT_READY.
- WAIT_READY:
  - filterReady=1 goes to START.
- START:
  - start=1 for exactly one cycle, then FILTER.
- FILTER:
  - filterDone=1 goes to READ.
- READ:
  - readHistogram=1.
  - The histogram presents bins in ascending index order, 0..NBINS-1. xValid and yValid for the same bin are asserted in the same cycle.
  - A bin is accepted only when xValid&yValid; each accepted bin increments the internal index.
  - xValid≠yValid in a cycle is ignored and counted as a stall cycle.
  - After bin NBINS-1 is accepted, go to DONE.
- DONE:
  - frameDone=1 for one cycle.
  - Latch the peak index/value registers; they hold until the next DONE.
  - Go to IDLE.
- ERROR:
  - Entered from CLEAR, WAIT_READY, FILTER or READ when the phase counter reaches TIMEOUT.
  - Deasserts all datapath controls and sets frameError.
  - Goes to IDLE next cycle; there is no frameDone.
- Phase counter: reset to 0 on every state change; in READ it also resets on every accepted bin.
- Peak rule:
  - Running max per axis, updated only on an accepted bin whose value is strictly greater than the running max, so ties keep the lowest index.
  - The initial running max is value 0, index 0, so an all-zero histogram reports index 0, value 0.
- frameReq outside IDLE is ignored; there is no queueing.

## Timing
- Reset values: state IDLE; every output 0, including the peak registers and frameError.
- Inputs are sampled registered, so each transition happens on the edge after its qualifying input.
- start: asserted the cycle after filterReady is seen, for 1 cycle.
- binIndex/xBin/yBin/binValid: registered, with 1-cycle latency from the accepted xValid&yValid.
- frameDone: asserts 2 cycles after the final bin is accepted. That is 1 cycle to register the last bin, then the DONE state; the peak registers are updated in the same cycle frameDone is high.
- Minimum frame overhead with ready handshakes: CLEAR(1)+WAIT_READY(1)+START(1) before the filter runs.
- Reset asserted mid-frame: immediate return to IDLE with all outputs 0; no pulses are emitted on release.
- Simultaneous timeout and qualifying input in the same cycle: the qualifying input wins.

## Structure
- Shared package:
  - the state enumeration;
  - NBINS_DEFAULT, TIMEOUT_DEFAULT and IDX_W=8, shared with the histogram compute block.
- Sub-module peak_tracker, one instance per axis:
  - inputs: clear, valid, index, value;
  - outputs: maxIndex, maxValue (strict-greater update).
- The FSM, phase counter and bin index counter stay in the top.

## Test plan
- Nominal frame: frameReq=1, histogramClear after 2 cycles, filterReady=1, filterDone after 100 cycles, 256 valid bins with x[i]=i%200 and y[i]=255-i -> one start pulse; 256 binValid beats with binIndex 0..255; xPeak=199/199; yPeak=0/255; one frameDone; frameError=0.
- Ties and zero: all bins 0, then a run with bins 10 and 20 both 50 -> peak 0/0, then peak index 10, value 50.
- Watchdog: filterDone never asserts -> ERROR after TIMEOUT cycles in FILTER; frameError=1; no frameDone. The next frameReq clears frameError.
- Valid skew: xValid without yValid on a bin for 3 cycles, then both -> the bin is accepted once; index does not skip; no timeout.
- Reset mid-READ at bin 128 -> all outputs 0 immediately; a new frame then restarts at binIndex 0 with fresh peaks.
- frameReq held high through a frame -> a second frame starts the cycle after returning to IDLE; frameReq pulses while busy are ignored.

Source files
------------

// File: rtl/histogram_sequencer_pkg.sv
// histogram_sequencer_pkg
// Shared definitions for the frame sequencer and the histogram compute block:
// sequencer state encoding, default sizing and the bin index width.
package histogram_sequencer_pkg;

  localparam int NBINS_DEFAULT   = 256;
  localparam int TIMEOUT_DEFAULT = 1048575;
  localparam int IDX_W           = 8;   // bin index and bin count width
  localparam int PH_W            = 20;  // phase (watchdog) counter width

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WAIT_READY,
    ST_START,
    ST_FILTER,
    ST_READ,
    ST_DONE,
    ST_ERROR
  } seq_state_t;

endpackage

// File: rtl/histogram_sequencer_peak.sv
// peak_tracker
// Running maximum of one histogram axis. A bin replaces the running max only
// when its value is strictly greater, so ties keep the lowest index. Clearing
// returns to index 0 / value 0, which is also the answer for an all-zero axis.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   clear             restart the running max (frame start)
//   valid             accepted bin this cycle
//   index, value      bin index and bin count
//   maxIndex/maxValue running max index/value
module peak_tracker
  import histogram_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             valid,
  input  logic [IDX_W-1:0] index,
  input  logic [IDX_W-1:0] value,
  output logic [IDX_W-1:0] maxIndex,
  output logic [IDX_W-1:0] maxValue
);

  logic [IDX_W-1:0] r_maxIdx;
  logic [IDX_W-1:0] r_maxVal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_maxIdx <= '0;
      r_maxVal <= '0;
    end else if (clear) begin
      r_maxIdx <= '0;
      r_maxVal <= '0;
    end else if (valid && (value > r_maxVal)) begin
      r_maxIdx <= index;
      r_maxVal <= value;
    end
  end

  assign maxIndex = r_maxIdx;
  assign maxValue = r_maxVal;

endmodule

// File: rtl/histogram_sequencer.sv
// histogram_sequencer
// Frame controller for the median-filter/histogram datapath: clears the
// histogram, starts the filter, waits for completion, then forwards the X/Y
// projection bins while tracking each axis's peak. A per-phase watchdog aborts
// any wait state that stalls.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   frameReq                       frame request (level, sampled in IDLE)
//   frameBusy/frameDone/frameError frame status
//   start                          one-cycle start to filter/histogram
//   filterReady, filterDone        filter handshake
//   clearHistogram, histogramClear histogram clear request/ack
//   readHistogram                  histogram readout enable
//   xValid/yValid, x/yHistogramOut incoming bins
//   binIndex, xBin, yBin, binValid forwarded (registered) bins
//   x/yPeakIndex, x/yPeakValue     peak of the last completed frame
module histogram_sequencer
  import histogram_sequencer_pkg::*;
#(
  parameter int NBINS   = NBINS_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frameReq,
  output logic             frameBusy,
  output logic             frameDone,
  output logic             frameError,
  output logic             start,
  input  logic             filterReady,
  input  logic             filterDone,
  output logic             clearHistogram,
  input  logic             histogramClear,
  output logic             readHistogram,
  input  logic             xValid,
  input  logic             yValid,
  input  logic [IDX_W-1:0] xHistogramOut,
  input  logic [IDX_W-1:0] yHistogramOut,
  output logic [IDX_W-1:0] binIndex,
  output logic [IDX_W-1:0] xBin,
  output logic [IDX_W-1:0] yBin,
  output logic             binValid,
  output logic [IDX_W-1:0] xPeakIndex,
  output logic [IDX_W-1:0] yPeakIndex,
  output logic [IDX_W-1:0] xPeakValue,
  output logic [IDX_W-1:0] yPeakValue
);

  seq_state_t       r_state, w_next;
  logic [PH_W-1:0]  r_phase;
  logic [IDX_W-1:0] r_idx;
  logic             r_lastSeen;   // final bin accepted last cycle
  logic             r_frameError;
  logic [IDX_W-1:0] r_binIdx, r_xBin, r_yBin;
  logic             r_binValid;
  logic [IDX_W-1:0] r_xPkIdx, r_xPkVal, r_yPkIdx, r_yPkVal;

  logic             w_frameStart;
  logic             w_accept;
  logic             w_lastIdx;
  logic             w_timeout;
  logic             w_start, w_clear, w_read, w_done, w_busy;
  logic [IDX_W-1:0] w_xMaxIdx, w_xMaxVal, w_yMaxIdx, w_yMaxVal;

  assign w_frameStart = (r_state == ST_IDLE) && frameReq;
  // Once the final bin is in, further strobes are ignored while it registers.
  assign w_accept     = (r_state == ST_READ) && xValid && yValid && !r_lastSeen;
  assign w_lastIdx    = (r_idx == IDX_W'(NBINS - 1));
  // The phase counter reads 0 in the first cycle of a phase, so this fires in
  // the TIMEOUT-th cycle spent waiting and the abort lands on the next edge.
  assign w_timeout    = (r_phase == PH_W'(TIMEOUT - 1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Qualifying inputs are tested before the watchdog so they win a tie.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_clear = 1'b0;
    w_read  = 1'b0;
    w_done  = 1'b0;
    w_busy  = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (frameReq) w_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        w_clear = 1'b1;
        if (histogramClear) w_next = ST_WAIT_READY;
        else if (w_timeout) w_next = ST_ERROR;
      end
      ST_WAIT_READY: begin
        if (filterReady)    w_next = ST_START;
        else if (w_timeout) w_next = ST_ERROR;
      end
      ST_START: begin
        w_start = 1'b1;
        w_next  = ST_FILTER;
      end
      ST_FILTER: begin
        if (filterDone)     w_next = ST_READ;
        else if (w_timeout) w_next = ST_ERROR;
      end
      ST_READ: begin
        w_read = 1'b1;
        if (r_lastSeen)                 w_next = ST_DONE;
        else if (!w_accept && w_timeout) w_next = ST_ERROR;
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      ST_ERROR: begin
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------- phase counter
  // Restarts on every state change and on every accepted bin; saturates so
  // a long IDLE cannot wrap it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              r_phase <= '0;
    else if ((w_next != r_state) || w_accept) r_phase <= '0;
    else if (r_phase != '1)                 r_phase <= r_phase + PH_W'(1);
  end

  // ---------------------------------------------------- bin index / flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx        <= '0;
      r_lastSeen   <= 1'b0;
      r_frameError <= 1'b0;
    end else begin
      if (w_frameStart)  r_idx <= '0;
      else if (w_accept) r_idx <= r_idx + IDX_W'(1);
      r_lastSeen <= w_accept && w_lastIdx;
      if (w_frameStart)           r_frameError <= 1'b0;
      else if (w_next == ST_ERROR) r_frameError <= 1'b1;
    end
  end

  // ------------------------------------------------------ forwarded bins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_binIdx   <= '0;
      r_xBin     <= '0;
      r_yBin     <= '0;
      r_binValid <= 1'b0;
    end else begin
      r_binValid <= w_accept;
      if (w_accept) begin
        r_binIdx <= r_idx;
        r_xBin   <= xHistogramOut;
        r_yBin   <= yHistogramOut;
      end
    end
  end

  // --------------------------------------------------------- peak tracking
  peak_tracker u_xPeak (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_frameStart),
    .valid    (w_accept),
    .index    (r_idx),
    .value    (xHistogramOut),
    .maxIndex (w_xMaxIdx),
    .maxValue (w_xMaxVal)
  );

  peak_tracker u_yPeak (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_frameStart),
    .valid    (w_accept),
    .index    (r_idx),
    .value    (yHistogramOut),
    .maxIndex (w_yMaxIdx),
    .maxValue (w_yMaxVal)
  );

  // Published on the edge into DONE so the new peaks appear with frameDone;
  // the trackers already hold the final bin by then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_xPkIdx <= '0;
      r_xPkVal <= '0;
      r_yPkIdx <= '0;
      r_yPkVal <= '0;
    end else if (r_lastSeen) begin
      r_xPkIdx <= w_xMaxIdx;
      r_xPkVal <= w_xMaxVal;
      r_yPkIdx <= w_yMaxIdx;
      r_yPkVal <= w_yMaxVal;
    end
  end

  // -------------------------------------------------------------- outputs
  assign frameBusy      = w_busy;
  assign frameDone      = w_done;
  assign frameError     = r_frameError;
  assign start          = w_start;
  assign clearHistogram = w_clear;
  assign readHistogram  = w_read;
  assign binIndex       = r_binIdx;
  assign xBin           = r_xBin;
  assign yBin           = r_yBin;
  assign binValid       = r_binValid;
  assign xPeakIndex     = r_xPkIdx;
  assign xPeakValue     = r_xPkVal;
  assign yPeakIndex     = r_yPkIdx;
  assign yPeakValue     = r_yPkVal;

endmodule

// File: tb/tb_histogram_sequencer.sv
// Directed bench for histogram_sequencer: nominal frame, ties/zero peaks,
// watchdog abort, valid skew, reset mid-READ and back-to-back frames.
module tb_histogram_sequencer;

  localparam int NB = 256;
  localparam int TO = 300;

  logic       clk = 1'b0;
  logic       reset;
  logic       frameReq, filterReady, filterDone, histogramClear;
  logic       xValid, yValid;
  logic [7:0] xH, yH;
  logic       frameBusy, frameDone, frameError, start;
  logic       clearHistogram, readHistogram, binValid;
  logic [7:0] binIndex, xBin, yBin;
  logic [7:0] xPeakIndex, yPeakIndex, xPeakValue, yPeakValue;

  int checks   = 0;
  int failures = 0;

  // Monitor-owned counters
  int beats = 0, monErr = 0, startCnt = 0, doneCnt = 0, expIdx = 0;
  logic [7:0] xv [NB];
  logic [7:0] yv [NB];

  histogram_sequencer #(.NBINS(NB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .frameReq(frameReq),
    .frameBusy(frameBusy), .frameDone(frameDone), .frameError(frameError),
    .start(start), .filterReady(filterReady), .filterDone(filterDone),
    .clearHistogram(clearHistogram), .histogramClear(histogramClear),
    .readHistogram(readHistogram), .xValid(xValid), .yValid(yValid),
    .xHistogramOut(xH), .yHistogramOut(yH), .binIndex(binIndex),
    .xBin(xBin), .yBin(yBin), .binValid(binValid),
    .xPeakIndex(xPeakIndex), .yPeakIndex(yPeakIndex),
    .xPeakValue(xPeakValue), .yPeakValue(yPeakValue)
  );

  always #5 clk = ~clk;

  // Beat monitor, sampled 2 time units after the rising edge.
  always @(posedge clk) begin
    #2;
    if (start)     startCnt++;
    if (frameDone) doneCnt++;
    if (!frameBusy) expIdx = 0;
    else if (binValid) begin
      beats++;
      if (expIdx >= NB || binIndex !== 8'(expIdx) ||
          xBin !== xv[expIdx] || yBin !== yv[expIdx]) monErr++;
      expIdx++;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // IDLE -> CLEAR -> WAIT_READY -> START -> FILTER; returns in first FILTER cycle.
  task automatic start_frame(input int clrDly, input logic hold);
    frameReq = 1'b1; filterReady = 1'b1; histogramClear = (clrDly == 0);
    tick();
    chk("clear_state", clearHistogram, 1);
    chk("busy_clear", frameBusy, 1);
    chk("err_cleared", frameError, 0);
    frameReq = hold;
    if (clrDly > 0) begin
      repeat (clrDly) tick();
      chk("clear_held", clearHistogram, 1);
      histogramClear = 1'b1;
    end
    tick();
    histogramClear = 1'b0;
    chk("wait_ready_ctl", {clearHistogram, start, readHistogram}, 0);
    tick();
    chk("start_pulse", start, 1);
    tick();
    chk("start_gone", start, 0);
  endtask

  task automatic run_filter(input int dly);
    repeat (dly) tick();
    chk("filter_no_read", readHistogram, 0);
    filterDone = 1'b1;
    tick();
    filterDone = 1'b0;
    chk("read_state", readHistogram, 1);
  endtask

  task automatic stream(input int stopAt, input int skewBin);
    for (int i = 0; i < NB; i++) begin
      if (i == stopAt) return;
      if (i == skewBin) begin
        xValid = 1'b1; yValid = 1'b0; xH = 8'd250; yH = 8'd0;
        repeat (3) tick();
      end
      xValid = 1'b1; yValid = 1'b1; xH = xv[i]; yH = yv[i];
      tick();
    end
    xValid = 1'b0; yValid = 1'b0;
  endtask

  task automatic finish_frame(input int xi, xval, yi, yval);
    chk("last_binValid", binValid, 1);
    chk("last_binIndex", binIndex, 255);
    chk("done_not_yet", frameDone, 0);
    tick();
    chk("frameDone", frameDone, 1);
    chk("xPeakIndex", xPeakIndex, xi);
    chk("xPeakValue", xPeakValue, xval);
    chk("yPeakIndex", yPeakIndex, yi);
    chk("yPeakValue", yPeakValue, yval);
    chk("no_error", frameError, 0);
    tick();
    chk("done_pulse_end", frameDone, 0);
    chk("idle_after_done", frameBusy, 0);
  endtask

  initial begin
    int b0, s0, d0, n;
    reset = 1'b1; frameReq = 0; filterReady = 0; filterDone = 0;
    histogramClear = 0; xValid = 0; yValid = 0; xH = 0; yH = 0;
    repeat (2) tick();
    chk("rst_outputs", {frameBusy, frameDone, frameError, start, clearHistogram,
                        readHistogram, binValid}, 0);
    chk("rst_bins", {binIndex, xBin, yBin}, 0);
    chk("rst_peaks", {xPeakIndex, yPeakIndex, xPeakValue, yPeakValue}, 0);
    reset = 1'b0;
    tick();

    // ---- nominal frame
    for (int i = 0; i < NB; i++) begin xv[i] = 8'(i % 200); yv[i] = 8'(255 - i); end
    b0 = beats; s0 = startCnt; d0 = doneCnt;
    start_frame(2, 1'b0);
    repeat (20) tick();
    frameReq = 1'b1;           // ignored while busy
    tick();
    frameReq = 1'b0;
    chk("req_ignored", {clearHistogram, start, readHistogram, frameBusy}, 4'b0001);
    run_filter(79);
    stream(NB, -1);
    finish_frame(199, 199, 0, 255);
    chk("nom_beats", beats - b0, 256);
    chk("nom_starts", startCnt - s0, 1);
    chk("nom_dones", doneCnt - d0, 1);
    chk("nom_mon", monErr, 0);

    // ---- ties and zero
    for (int i = 0; i < NB; i++) begin xv[i] = 8'd0; yv[i] = 8'd0; end
    start_frame(0, 1'b0);
    run_filter(3);
    stream(NB, -1);
    finish_frame(0, 0, 0, 0);
    xv[10] = 8'd50; xv[20] = 8'd50; yv[10] = 8'd50; yv[20] = 8'd50;
    start_frame(0, 1'b0);
    run_filter(3);
    stream(NB, -1);
    finish_frame(10, 50, 10, 50);

    // ---- watchdog in FILTER
    d0 = doneCnt;
    start_frame(0, 1'b0);
    n = 0;
    while (!frameError && n < 2 * TO) begin tick(); n++; end
    chk("wd_cycles", n, TO);
    chk("wd_error", frameError, 1);
    chk("wd_ctl_off", {start, clearHistogram, readHistogram, binValid}, 0);
    tick();
    chk("wd_idle", frameBusy, 0);
    chk("wd_sticky", frameError, 1);
    chk("wd_no_done", doneCnt - d0, 0);

    // ---- valid skew (frame also clears the sticky error)
    for (int i = 0; i < NB; i++) begin xv[i] = 8'(i % 200); yv[i] = 8'(255 - i); end
    b0 = beats;
    start_frame(1, 1'b0);
    run_filter(5);
    stream(NB, 5);
    finish_frame(199, 199, 0, 255);
    chk("skew_beats", beats - b0, 256);
    chk("skew_mon", monErr, 0);

    // ---- reset mid-READ at bin 128
    start_frame(0, 1'b0);
    run_filter(2);
    stream(128, -1);
    xH = xv[128]; yH = yv[128];
    reset = 1'b1;
    #1;
    chk("mid_rst_status", {frameBusy, frameDone, frameError, start, readHistogram, binValid}, 0);
    chk("mid_rst_bins", {binIndex, xBin, yBin}, 0);
    chk("mid_rst_peaks", {xPeakIndex, yPeakIndex, xPeakValue, yPeakValue}, 0);
    xValid = 1'b0; yValid = 1'b0;
    tick();
    reset = 1'b0;
    s0 = startCnt; d0 = doneCnt;
    repeat (2) tick();
    chk("rel_no_pulses", {startCnt - s0, doneCnt - d0}, 0);
    chk("rel_idle", frameBusy, 0);
    for (int i = 0; i < NB; i++) begin xv[i] = 8'd7; yv[i] = 8'(i); end
    xv[3] = 8'd9;
    b0 = beats;
    start_frame(0, 1'b0);
    run_filter(1);
    tick();                     // one idle READ cycle before bins arrive
    chk("restart_idx0", binValid, 0);
    stream(NB, -1);
    finish_frame(3, 9, 255, 255);
    chk("restart_beats", beats - b0, 256);
    chk("restart_mon", monErr, 0);

    // ---- frameReq held: back-to-back frames
    start_frame(0, 1'b1);
    run_filter(2);
    stream(NB, -1);
    chk("held_last_bin", binIndex, 255);
    tick();
    chk("held_done", frameDone, 1);
    tick();
    chk("held_idle", frameBusy, 0);
    tick();
    chk("held_restart", clearHistogram, 1);
    chk("held_peak_kept", xPeakValue, 9);
    frameReq = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the run always terminates.
  initial begin
    #500000;
    $display("FAIL timeout global_guard observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
